// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read/status bundle for the parameterised synchronous FIFO
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic              ren;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              ovf;
    logic              udf;
    logic [CW-1:0]     count;

    modport master (
        output wdata, wen, ren, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, ovf, udf, count
    );

    modport slave (
        input  wdata, wen, ren, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty, ovf, udf, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with registered read data, threshold flags and sticky error flags
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input logic               i_clk,
    input logic               i_rst,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_ovf;
    logic              r_udf;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [CW-1:0]     w_count_nxt;

    // A simultaneous read frees the slot a write into a full FIFO needs; the reverse never applies.
    always_comb begin
        w_rd_acc = bus.ren && !r_empty;
        w_wr_acc = bus.wen && (!r_full || w_rd_acc);
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ovf          <= 1'b0;
            r_udf          <= 1'b0;
            r_rdata        <= '0;
            r_rvalid       <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr  <= r_rptr + AW'(1);
                r_rdata <= r_mem[r_rptr];
            end
            r_rvalid       <= w_rd_acc;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
            // A new error in the same cycle as a clear wins.
            if (bus.wen && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end
            if (bus.ren && !w_rd_acc) begin
                r_udf <= 1'b1;
            end else if (bus.clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign bus.rdata        = r_rdata;
    assign bus.rvalid       = r_rvalid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.ovf          = r_ovf;
    assign bus.udf          = r_udf;
    assign bus.count        = r_count;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param against a queue-based reference
module tb_sync_fifo_param;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 256;
    localparam int AF_LEVEL = DEPTH - 4;
    localparam int AE_LEVEL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_rvalid = 1'b0;
    logic              exp_ovf = 1'b0;
    logic              exp_udf = 1'b0;
    int                n_vec = 0;
    int                n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count", 32'(bus.count), 32'(sz));
        chk("full", 32'(bus.full), 32'(sz == DEPTH));
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(sz >= AF_LEVEL));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_LEVEL));
        chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
        chk("udf", 32'(bus.udf), 32'(exp_udf));
        chk("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
        chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
    endtask

    task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re,
                        input logic ce, input logic rs);
        logic rd_ok;
        logic wr_ok;
        @(negedge clk);
        bus.wen     = we;
        bus.wdata   = wd;
        bus.ren     = re;
        bus.clr_err = ce;
        rst         = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_rdata  = '0;
            exp_rvalid = 1'b0;
            exp_ovf    = 1'b0;
            exp_udf    = 1'b0;
        end else begin
            rd_ok = re && (q.size() > 0);
            wr_ok = we && ((q.size() < DEPTH) || rd_ok);
            exp_rvalid = rd_ok;
            if (rd_ok) exp_rdata = q.pop_front();
            if (wr_ok) q.push_back(wd);
            if (we && !wr_ok) exp_ovf = 1'b1;
            else if (ce) exp_ovf = 1'b0;
            if (re && !rd_ok) exp_udf = 1'b1;
            else if (ce) exp_udf = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_clr();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.wen     = 1'b0;
        bus.ren     = 1'b0;
        bus.clr_err = 1'b0;
        bus.wdata   = '0;

        step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_count", 32'(bus.count), 32'd0);

        wr(8'h11); wr(8'h22); wr(8'h33);
        rd(); chk("basic_rd0", 32'(bus.rdata), 32'h11);
        rd(); chk("basic_rd1", 32'(bus.rdata), 32'h22);
        rd(); chk("basic_rd2", 32'(bus.rdata), 32'h33);
        chk("basic_rvalid", 32'(bus.rvalid), 32'd1);
        chk("basic_end_empty", 32'(bus.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) wr(DATA_W'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd256);
        wr(8'hEE);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd256);
        for (int i = 0; i < DEPTH; i++) begin
            rd();
            chk("drain_order", 32'(bus.rdata), 32'(i));
        end
        idle_clr();
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);

        for (int i = 0; i < DEPTH; i++) wr(DATA_W'($urandom));
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        chk("full_rw_count", 32'(bus.count), 32'd256);
        chk("full_rw_full", 32'(bus.full), 32'd1);
        chk("full_rw_ovf", 32'(bus.ovf), 32'd0);
        while (q.size() > 0) rd();

        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_udf", 32'(bus.udf), 32'd1);
        chk("empty_rw_count", 32'(bus.count), 32'd1);
        rd();
        chk("empty_rw_data", 32'(bus.rdata), 32'hA5);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("udf_clr_collision", 32'(bus.udf), 32'd1);
        idle_clr();

        for (int i = 0; i < AF_LEVEL; i++) wr(DATA_W'($urandom));
        chk("af_at_level", 32'(bus.almost_full), 32'd1);
        while (q.size() > AE_LEVEL) rd();
        chk("ae_at_level", 32'(bus.almost_empty), 32'd1);
        for (int i = 0; i < 600; i++) step(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1200; i++)
            step(1'($urandom_range(0, 9) < 6), DATA_W'($urandom), 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 15) == 0), 1'b0);
        for (int i = 0; i < 1200; i++)
            step(1'($urandom_range(0, 9) < 4), DATA_W'($urandom), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 15) == 0), 1'b0);

        while (q.size() < DEPTH) wr(DATA_W'($urandom));
        wr(8'h77);
        while (q.size() > 10) rd();
        chk("pre_rst_count", 32'(bus.count), 32'd10);
        chk("pre_rst_ovf", 32'(bus.ovf), 32'd1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
